// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, ALU functions, condition codes,
// register ids and the instruction-length table used for fall-through PCs.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  typedef enum logic [1:0] {AluAdd, AluSub, AluAnd, AluXor} alu_fn_e;

  localparam logic [3:0] C_ALWAYS = 4'h0;
  localparam logic [3:0] C_LE     = 4'h1;
  localparam logic [3:0] C_L      = 4'h2;
  localparam logic [3:0] C_E      = 4'h3;
  localparam logic [3:0] C_NE     = 4'h4;
  localparam logic [3:0] C_GE     = 4'h5;
  localparam logic [3:0] C_G      = 4'h6;

  localparam logic [3:0] RSP   = 4'h4;
  localparam logic [3:0] RNONE = 4'hF;

  // Encoded length in bytes; unknown codes advance by one byte.
  function automatic logic [3:0] instr_len(input logic [3:0] icode);
    unique case (icode)
      I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ: instr_len = 4'd2;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:     instr_len = 4'd10;
      I_JXX, I_CALL:                    instr_len = 4'd9;
      default:                          instr_len = 4'd1;
    endcase
  endfunction

endpackage

// File: rtl/y86_alu.sv
// 64-bit Y86 ALU computing b OP a with zero/sign/overflow flags.
module y86_alu
  import y86_pkg::*;
(
  input  logic [63:0] a_i,
  input  logic [63:0] b_i,
  input  logic [1:0]  fn_i,
  output logic [63:0] res_o,
  output logic        zf_o,
  output logic        sf_o,
  output logic        of_o
);

  always_comb begin
    res_o = '0;
    of_o  = 1'b0;
    unique case (alu_fn_e'(fn_i))
      AluAdd: begin
        res_o = b_i + a_i;
        of_o  = (a_i[63] == b_i[63]) && (res_o[63] != a_i[63]);
      end
      AluSub: begin
        res_o = b_i - a_i;
        of_o  = (a_i[63] != b_i[63]) && (res_o[63] != b_i[63]);
      end
      AluAnd: res_o = b_i & a_i;
      AluXor: res_o = b_i ^ a_i;
      default: res_o = '0;
    endcase
  end

  assign zf_o = (res_o == '0);
  assign sf_o = res_o[63];

endmodule

// File: rtl/y86_fdew_core.sv
// Single-cycle Y86-64 fetch/decode/execute/writeback; PC update and data
// memory live outside this block.
module y86_fdew_core
  import y86_pkg::*;
#(
  parameter int unsigned PC_LIMIT = 1023
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [63:0]  pc,
  input  logic [79:0]  instr,
  input  logic [63:0]  valM,
  output logic [3:0]   icode,
  output logic [3:0]   ifun,
  output logic [3:0]   rA,
  output logic [3:0]   rB,
  output logic [63:0]  valC,
  output logic [63:0]  valP,
  output logic [63:0]  valA,
  output logic [63:0]  valB,
  output logic [63:0]  valE,
  output logic         cnd,
  output logic [2:0]   cc,
  output logic         halt,
  output logic         instr_valid,
  output logic         pc_err,
  output logic [959:0] regs_flat
);

  logic [63:0] regs_q [15];
  logic [63:0] regs_d [15];
  logic [2:0]  cc_q, cc_d;

  logic [3:0]  src_a, src_b, dst_e, dst_m;
  logic [63:0] alu_res;
  logic        alu_zf, alu_sf, alu_of;
  logic        op_ok, commit;
  logic        zf, sf, of;

  assign icode       = instr[79:76];
  assign ifun        = instr[75:72];
  assign halt        = (icode == I_HALT);
  assign instr_valid = (icode <= I_POPQ);
  assign pc_err      = (pc > 64'(PC_LIMIT));
  assign valP        = pc + 64'(instr_len(icode));
  assign op_ok       = (ifun <= 4'd3);
  assign commit      = instr_valid && !halt && !pc_err;
  assign {zf, sf, of} = cc_q;

  always_comb begin
    rA   = RNONE;
    rB   = RNONE;
    valC = '0;
    if (icode inside {I_RRMOVQ, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ, I_OPQ, I_PUSHQ, I_POPQ}) begin
      rA = instr[71:68];
      rB = instr[67:64];
    end
    // Constant is little-endian: lowest byte sits first in the window.
    for (int j = 0; j < 8; j++) begin
      if (icode inside {I_IRMOVQ, I_RMMOVQ, I_MRMOVQ}) valC[8*j +: 8] = instr[63-8*j -: 8];
      else if (icode inside {I_JXX, I_CALL})           valC[8*j +: 8] = instr[71-8*j -: 8];
    end
  end

  always_comb begin
    src_a = RNONE;
    src_b = RNONE;
    if (icode inside {I_RRMOVQ, I_RMMOVQ, I_OPQ, I_PUSHQ}) src_a = rA;
    else if (icode inside {I_RET, I_POPQ})                 src_a = RSP;
    if (icode inside {I_RMMOVQ, I_MRMOVQ, I_OPQ})          src_b = rB;
    else if (icode inside {I_CALL, I_RET, I_PUSHQ, I_POPQ}) src_b = RSP;
  end

  assign valA = (src_a == RNONE) ? '0 : regs_q[src_a];
  assign valB = (src_b == RNONE) ? '0 : regs_q[src_b];

  y86_alu u_alu (
    .a_i   (valA),
    .b_i   (valB),
    .fn_i  (ifun[1:0]),
    .res_o (alu_res),
    .zf_o  (alu_zf),
    .sf_o  (alu_sf),
    .of_o  (alu_of)
  );

  always_comb begin
    valE = '0;
    unique case (icode)
      I_RRMOVQ:           valE = valA;
      I_IRMOVQ:           valE = valC;
      I_RMMOVQ, I_MRMOVQ: valE = valB + valC;
      I_OPQ:              valE = op_ok ? alu_res : '0;
      I_CALL, I_PUSHQ:    valE = valB - 64'd8;
      I_RET, I_POPQ:      valE = valB + 64'd8;
      default:            valE = '0;
    endcase
  end

  always_comb begin
    cnd = 1'b0;
    if (icode inside {I_RRMOVQ, I_JXX}) begin
      unique case (ifun)
        C_ALWAYS: cnd = 1'b1;
        C_LE:     cnd = (sf ^ of) | zf;
        C_L:      cnd = sf ^ of;
        C_E:      cnd = zf;
        C_NE:     cnd = !zf;
        C_GE:     cnd = !(sf ^ of);
        C_G:      cnd = !(sf ^ of) && !zf;
        default:  cnd = 1'b0;
      endcase
    end
  end

  always_comb begin
    dst_e = RNONE;
    dst_m = RNONE;
    unique case (icode)
      I_IRMOVQ:                        dst_e = rB;
      I_OPQ:                           dst_e = op_ok ? rB : RNONE;
      I_RRMOVQ:                        dst_e = cnd ? rB : RNONE;
      I_CALL, I_RET, I_PUSHQ, I_POPQ:  dst_e = RSP;
      default:                         dst_e = RNONE;
    endcase
    if (icode inside {I_MRMOVQ, I_POPQ}) dst_m = rA;
  end

  always_comb begin
    regs_d = regs_q;
    cc_d   = cc_q;
    if (commit) begin
      if (icode == I_OPQ && op_ok) cc_d = {alu_zf, alu_sf, alu_of};
      if (dst_e != RNONE) regs_d[dst_e] = valE;
      // Applied second so the memory value wins on a shared destination.
      if (dst_m != RNONE) regs_d[dst_m] = valM;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regs_q <= '{default: '0};
      cc_q   <= 3'b100;
    end else begin
      regs_q <= regs_d;
      cc_q   <= cc_d;
    end
  end

  assign cc = cc_q;

  for (genvar i = 0; i < 15; i++) begin : g_flat
    assign regs_flat[64*i +: 64] = regs_q[i];
  end

endmodule

// File: tb/tb_y86_fdew_core.sv
// Scoreboard bench: driver pushes reference-model predictions, monitor pops and
// compares at the falling edge.
module tb_y86_fdew_core;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [63:0]  pc;
  logic [79:0]  instr;
  logic [63:0]  valM;
  logic [3:0]   icode, ifun, rA, rB;
  logic [63:0]  valC, valP, valA, valB, valE;
  logic         cnd, halt, instr_valid, pc_err;
  logic [2:0]   cc;
  logic [959:0] regs_flat;

  y86_fdew_core dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc          (pc),
    .instr       (instr),
    .valM        (valM),
    .icode       (icode),
    .ifun        (ifun),
    .rA          (rA),
    .rB          (rB),
    .valC        (valC),
    .valP        (valP),
    .valA        (valA),
    .valB        (valB),
    .valE        (valE),
    .cnd         (cnd),
    .cc          (cc),
    .halt        (halt),
    .instr_valid (instr_valid),
    .pc_err      (pc_err),
    .regs_flat   (regs_flat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  ic, fn, ra, rb;
    logic [63:0] vc, vp, va, vb, ve;
    logic        cnd, hlt, iv, perr;
    logic [2:0]  cc;
    logic [63:0] regs [15];
  } exp_t;

  exp_t sb_q[$];
  int tests = 0;
  int fails = 0;

  logic [63:0] m_regs [15];
  logic [2:0]  m_cc;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk("icode", 64'(icode), 64'(e.ic));
      chk("ifun", 64'(ifun), 64'(e.fn));
      chk("rA", 64'(rA), 64'(e.ra));
      chk("rB", 64'(rB), 64'(e.rb));
      chk("valC", valC, e.vc);
      chk("valP", valP, e.vp);
      chk("valA", valA, e.va);
      chk("valB", valB, e.vb);
      chk("valE", valE, e.ve);
      chk("cnd", 64'(cnd), 64'(e.cnd));
      chk("halt", 64'(halt), 64'(e.hlt));
      chk("instr_valid", 64'(instr_valid), 64'(e.iv));
      chk("pc_err", 64'(pc_err), 64'(e.perr));
      chk("cc", 64'(cc), 64'(e.cc));
      for (int i = 0; i < 15; i++) chk($sformatf("r%0d", i), regs_flat[64*i +: 64], e.regs[i]);
    end
  end

  function automatic logic [63:0] bswap(input logic [63:0] v);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[63-8*i -: 8] = v[8*i +: 8];
    return r;
  endfunction

  function automatic logic [79:0] irmov(input logic [3:0] rb, input logic [63:0] v);
    return {8'h30, 4'hF, rb, bswap(v)};
  endfunction

  function automatic logic [79:0] two(input logic [7:0] b0, input logic [7:0] b1);
    return {b0, b1, 64'h0};
  endfunction

  function automatic logic [79:0] jmp(input logic [7:0] b0, input logic [63:0] dest);
    return {b0, bswap(dest), 8'h00};
  endfunction

  function automatic logic [63:0] rd(input logic [3:0] r);
    return (r == 4'hF) ? 64'h0 : m_regs[r];
  endfunction

  // Reference model: Y86 semantics in plain arithmetic, one instruction per call.
  task automatic issue(input logic [63:0] p, input logic [79:0] ins, input logic [63:0] vm);
    exp_t e;
    logic [3:0] ic, fn, sa, sb, de, dm;
    logic [64:0] wide;
    logic ofl, upd, zf, sf, of, commit;
    ic = ins[79:76];
    fn = ins[75:72];
    pc = p; instr = ins; valM = vm;
    e.ic = ic; e.fn = fn;
    e.ra = 4'hF; e.rb = 4'hF; e.vc = '0;
    if (ic inside {2, 3, 4, 5, 6, 10, 11}) begin
      e.ra = ins[71:68]; e.rb = ins[67:64];
    end
    if (ic inside {3, 4, 5}) e.vc = bswap(ins[63:0]);
    if (ic inside {7, 8}) e.vc = bswap(ins[71:8]);
    case (ic)
      2, 6, 10, 11: e.vp = p + 2;
      3, 4, 5:      e.vp = p + 10;
      7, 8:         e.vp = p + 9;
      default:      e.vp = p + 1;
    endcase
    sa = 4'hF; sb = 4'hF;
    if (ic inside {2, 4, 6, 10}) sa = e.ra;
    if (ic inside {9, 11}) sa = 4'd4;
    if (ic inside {4, 5, 6}) sb = e.rb;
    if (ic inside {8, 9, 10, 11}) sb = 4'd4;
    e.va = rd(sa); e.vb = rd(sb);
    ofl = 1'b0; upd = 1'b0;
    case (ic)
      2: e.ve = e.va;
      3: e.ve = e.vc;
      4, 5: e.ve = e.vb + e.vc;
      6: begin
        upd = (fn <= 3);
        case (fn)
          0: begin
            wide = {e.vb[63], e.vb} + {e.va[63], e.va};
            e.ve = wide[63:0]; ofl = wide[64] ^ wide[63];
          end
          1: begin
            wide = {e.vb[63], e.vb} - {e.va[63], e.va};
            e.ve = wide[63:0]; ofl = wide[64] ^ wide[63];
          end
          2: e.ve = e.va & e.vb;
          3: e.ve = e.va ^ e.vb;
          default: e.ve = 0;
        endcase
      end
      8, 10: e.ve = e.vb - 8;
      9, 11: e.ve = e.vb + 8;
      default: e.ve = 0;
    endcase
    {zf, sf, of} = m_cc;
    e.cnd = 1'b0;
    if (ic == 2 || ic == 7) begin
      case (fn)
        0: e.cnd = 1;
        1: e.cnd = (sf != of) || zf;
        2: e.cnd = (sf != of);
        3: e.cnd = zf;
        4: e.cnd = !zf;
        5: e.cnd = (sf == of);
        6: e.cnd = (sf == of) && !zf;
        default: e.cnd = 0;
      endcase
    end
    e.hlt = (ic == 0);
    e.iv = (ic <= 11);
    e.perr = (p > 1023);
    e.cc = m_cc;
    e.regs = m_regs;
    sb_q.push_back(e);
    commit = e.iv && !e.hlt && !e.perr;
    de = 4'hF; dm = 4'hF;
    if (ic == 3 || (ic == 6 && fn <= 3) || (ic == 2 && e.cnd)) de = e.rb;
    if (ic inside {8, 9, 10, 11}) de = 4'd4;
    if (ic inside {5, 11}) dm = e.ra;
    if (commit) begin
      if (upd) m_cc = {e.ve == 0, e.ve[63], ofl};
      if (de != 4'hF) m_regs[de] = e.ve;
      if (dm != 4'hF) m_regs[dm] = vm;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [79:0] ins;
    logic [63:0] p;
    int r;
    m_regs = '{default: '0};
    m_cc = 3'b100;
    rst_n = 1'b0; pc = '0; instr = '0; valM = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    issue(0, irmov(4'd2, 64'hFFFF_FFFF_FFFF_FFFF), 0);
    issue(10, irmov(4'd3, 64'd1), 0);
    issue(20, two(8'h60, 8'h23), 0);
    issue(22, irmov(4'd9, 64'd5), 0);
    issue(32, irmov(4'd10, 64'd3), 0);
    issue(42, two(8'h61, 8'h9A), 0);
    issue(44, irmov(4'd0, 64'h7FFF_FFFF_FFFF_FFFF), 0);
    issue(54, irmov(4'd1, 64'd1), 0);
    issue(64, two(8'h60, 8'h01), 0);
    issue(66, jmp(8'h72, 64'h200), 0);
    issue(75, jmp(8'h71, 64'h200), 0);
    issue(84, jmp(8'h74, 64'h200), 0);
    issue(93, irmov(4'd4, 64'h100), 0);
    issue(103, two(8'hA0, 8'h3F), 0);
    issue(105, two(8'hB0, 8'h4F), 64'h55);
    issue(38, two(8'hC0, 8'h00), 64'h77);
    issue(39, two(8'h00, 8'h00), 64'h77);
    issue(1024, irmov(4'd7, 64'h1234), 0);
    issue(1024, two(8'h60, 8'h01), 0);
    issue(200, irmov(4'd5, 64'd0), 0);
    issue(210, two(8'h62, 8'h55), 0);
    issue(212, two(8'h21, 8'h01), 0);
    issue(214, irmov(4'd5, 64'd1), 0);
    issue(224, two(8'h62, 8'h55), 0);
    issue(226, two(8'h21, 8'h01), 0);
    issue(1023, two(8'h60, 8'h12), 0);

    for (int n = 0; n < 400; n++) begin
      ins = {$urandom(), $urandom(), 16'($urandom())};
      r = $urandom_range(0, 21);
      if (r < 16) ins[79:76] = 4'(r);
      else if (r < 19) ins[79:76] = 4'h6;
      else ins[79:76] = 4'h2;
      if (ins[79:76] == 4'h6) ins[75:72] = 4'($urandom_range(0, 4));
      else if (ins[79:76] inside {4'h2, 4'h7}) ins[75:72] = 4'($urandom_range(0, 7));
      if ($urandom_range(0, 24) == 0) p = 64'd1024 + 64'($urandom());
      else p = 64'($urandom_range(0, 1023));
      issue(p, ins, {$urandom(), $urandom()});
    end
    issue(0, two(8'h00, 8'h00), 0);

    @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/y86_fdew_core.md
Name: y86_fdew_core

Overview:
- Single-cycle Y86-64 front half: fetch decode, register-file read, ALU execute with condition codes, and register writeback.
- Takes the PC and a 10-byte instruction window from the external instruction memory.
- Takes valM from the external memory stage.
- Produces all SEQ stage values. PC update and data memory stay outside this block.

Parameters:
- PC_LIMIT, 1023: highest legal PC; any larger PC raises pc_err.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- pc  in  64  current PC.
- instr  in  80  bytes pc..pc+9; byte pc occupies bits [79:72].
- valM  in  64  memory read data for the current instruction.
- icode, ifun, rA, rB  out  4 each  decoded fields.
- valC  out  64  constant, little-endian.
- valP  out  64  fall-through PC.
- valA, valB  out  64  register reads.
- valE  out  64  ALU result.
- cnd  out  1  condition result.
- cc  out  3  {ZF,SF,OF}.
- halt  out  1  icode==0.
- instr_valid  out  1  icode<=0xB.
- pc_err  out  1  pc>PC_LIMIT.
- regs_flat  out  960  r0..r14; r0 in [63:0].

Behaviour:
- Fetch (combinational):
  - icode=instr[79:76], ifun=instr[75:72].
  - For icode 2,3,4,5,6,A,B: rA=instr[71:68], rB=instr[67:64]. Otherwise rA=rB=0xF.
  - valC for 3,4,5: bytes 2..9 little-endian. For 7,8: bytes 1..8 little-endian. Otherwise 0.
- valP:
  - pc+1 for 0,1,9.
  - pc+2 for 2,6,A,B.
  - pc+10 for 3,4,5.
  - pc+9 for 7,8.
  - pc+1 for an invalid icode.
- Decode (combinational):
  - srcA = rA for icode 2,4,6,A; rsp (r4) for 9,B; else none.
  - srcB = rB for 4,5,6; rsp for 8,9,A,B; else none.
  - Register 0xF (none) reads as 0.
- Execute (combinational):
  - icode 2: valE=valA+0.
  - icode 3: valE=valC.
  - icode 4, 5: valE=valB+valC.
  - icode 6: ifun 0 add valB+valA, 1 sub valB-valA, 2 and, 3 xor.
  - icode 8, A: valE=valB-8.
  - icode 9, B: valE=valB+8.
  - icode 7: valE=0.
  - All arithmetic is 64-bit two's-complement and wraps.
  - OF for add: operand signs equal and result sign differs.
  - OF for sub: valA and valB signs differ and result sign differs from valB.
  - and/xor: OF=0. ZF = result==0. SF = result[63].
- cnd, for icode 2 and 7 only, from the registered cc:
  - ifun 0: 1.
  - ifun 1: (SF^OF)|ZF.
  - ifun 2: SF^OF.
  - ifun 3: ZF.
  - ifun 4: !ZF.
  - ifun 5: !(SF^OF).
  - ifun 6: !(SF^OF)&!ZF.
  - ifun above 6: cnd=0.
  - Any other icode: cnd=0.
- Sequential (rising clk):
  - rst_n=0: r0..r14 <= 0, cc <= 3'b100. This overrides all else.
  - Commit condition for cc and register writes: instr_valid=1, halt=0 and pc_err=0. Otherwise no state changes.
  - cc updates only for icode 6 with ifun<=3.
  - dstE = rB for 3, 6, and 2 when cnd=1; rsp for 8,9,A,B.
  - dstM = rA for 5, B.
  - When dstE==dstM, the valM write wins (popq %rsp).
  - Writes to 0xF are dropped.
  - Invalid icode 6 ifun (above 3): valE=0, no cc or register update.
- All outputs except cc and regs_flat are combinational from the current inputs and state. Zero added latency.

Decomposition:
- y86_pkg holds:
  - icode constants (I_HALT..I_POPQ).
  - ALU function codes.
  - Condition codes.
  - RSP=4, RNONE=4'hF.
  - The valP length table.
- One sub-module y86_alu: 64-bit add/sub/and/xor plus ZF/SF/OF generation.

Test Plan:
- Reset: hold rst_n=0 one cycle, then irmovq $-1,%rdx (30 F2 FF×8) at pc=0. Require valC=0xFFFF_FFFF_FFFF_FFFF, valP=10, and after the edge r2=-1 with cc still 100.
- With r2=-1 and r3=1, addq %rdx,%rbx (60 23). Require valE=0, and after the edge cc=100 and r3=0. Then subq with r9=5, r10=3 (61 9A): valE=-2, cc=010.
- Overflow: r0=0x7FFF…FFFF, r1=1, addq (60 01). Require valE=0x8000…0000 and cc=011. Next, jl (72 + dest): cnd=0, valP=pc+9. jle: cnd=0. jne: cnd=1.
- Stack with r4=0x100: pushq %rbx (A0 3F) gives valE=0xF8, r4=0xF8. popq %rsp (B0 4F) with valM=0x55 gives r4=0x55 (valM wins).
- Invalid byte 0xC0 at pc=38: instr_valid=0, valP=39, no register or cc change. halt byte 00: halt=1, no state change.
- pc=1024: pc_err=1 and no writeback. cmovle (21 01) with cc=100: cnd=1, r1<=r0. With cc=000: cnd=0, r1 unchanged.
